transfer_dir_ctrl: RTL and testbench

TRANSFER_DIR_CTRL -- requirements
Module: transfer_dir_ctrl

---
 rtl/transfer_dir_ctrl_if.sv | 14 +
 rtl/transfer_dir_ctrl.sv | 80 ++++++++
 tb/tb_transfer_dir_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/transfer_dir_ctrl_if.sv
// transfer_dir_ctrl_if: per-channel stream, pad handshake and status bundle
interface transfer_dir_ctrl_if #(parameter int N = 4);
  logic [N-1:0]    dir_req, tx_valid, tx_ready, rx_valid, rx_ready, oen;
  logic [N-1:0]    REQ_SEND, ACK_SEND, REQ_RECV, ACK_RECV, busy, timeout_err, clear_err;
  logic [N*32-1:0] tx_data, rx_data, DAT_SEND, DAT_RECV;
  modport slave (
    input  dir_req, tx_valid, tx_data, rx_ready, ACK_SEND, REQ_RECV, DAT_RECV, clear_err,
    output tx_ready, rx_valid, rx_data, oen, REQ_SEND, DAT_SEND, ACK_RECV, busy, timeout_err
  );
  modport master (
    output dir_req, tx_valid, tx_data, rx_ready, ACK_SEND, REQ_RECV, DAT_RECV, clear_err,
    input  tx_ready, rx_valid, rx_data, oen, REQ_SEND, DAT_SEND, ACK_RECV, busy, timeout_err
  );
endinterface

// File: rtl/transfer_dir_ctrl.sv
// transfer_dir_ctrl: per-channel half-duplex direction FSM with 4-phase pad handshakes
module transfer_dir_ctrl #(
  parameter int All_Channel = 4,
  parameter int TURN_CYC    = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic               clk,
  input  logic               rst,
  transfer_dir_ctrl_if.slave bus
);
  localparam logic [2:0] RX_IDLE = 3'd0, RX_ACK = 3'd1, TURN_TX = 3'd2, TX_IDLE = 3'd3,
                         TX_REQ  = 3'd4, TX_REL = 3'd5, TURN_RX = 3'd6;
  genvar i;
  for (i = 0; i < All_Channel; i++) begin : g_ch
    logic [2:0]  st;
    logic [15:0] cnt;
    logic        rxv, err, tmo, turn_done, hit;
    logic [31:0] rxd, dsend;
    assign tmo       = cnt == 16'(TIMEOUT - 1);
    assign turn_done = cnt == 16'(TURN_CYC - 1);
    // a timeout only counts while the awaited handshake edge is still missing
    assign hit = tmo && ((st == RX_ACK && bus.REQ_RECV[i]) ||
                         (st == TX_REQ && !bus.ACK_SEND[i]) ||
                         (st == TX_REL && bus.ACK_SEND[i]));
    always_ff @(posedge clk) begin
      if (rst) begin
        st    <= RX_IDLE;
        cnt   <= '0;
        rxv   <= 1'b0;
        rxd   <= '0;
        dsend <= '0;
        err   <= 1'b0;
      end else begin
        cnt <= cnt + 16'd1;
        err <= (err & ~bus.clear_err[i]) | hit;
        if (rxv && bus.rx_ready[i]) rxv <= 1'b0;
        case (st)
          RX_IDLE:
            if (bus.dir_req[i]) begin
              st  <= TURN_TX;
              cnt <= '0;
            end else if (bus.REQ_RECV[i] && !rxv) begin
              rxd <= bus.DAT_RECV[i*32 +: 32];
              rxv <= 1'b1;
              st  <= RX_ACK;
              cnt <= '0;
            end
          RX_ACK:  if (!bus.REQ_RECV[i] || tmo) st <= RX_IDLE;
          TURN_TX: if (turn_done) st <= TX_IDLE;
          TX_IDLE:
            if (!bus.dir_req[i]) begin
              st  <= TURN_RX;
              cnt <= '0;
            end else if (bus.tx_valid[i]) begin
              dsend <= bus.tx_data[i*32 +: 32];
              st    <= TX_REQ;
              cnt   <= '0;
            end
          TX_REQ:
            if (bus.ACK_SEND[i]) begin
              st  <= TX_REL;
              cnt <= '0;
            end else if (tmo) st <= TX_IDLE;
          TX_REL:  if (!bus.ACK_SEND[i] || tmo) st <= TX_IDLE;
          TURN_RX: if (turn_done) st <= RX_IDLE;
          default: st <= RX_IDLE;
        endcase
      end
    end
    assign bus.oen[i]              = !(st inside {TX_IDLE, TX_REQ, TX_REL});
    assign bus.tx_ready[i]         = st == TX_IDLE;
    assign bus.REQ_SEND[i]         = st == TX_REQ;
    assign bus.ACK_RECV[i]         = st == RX_ACK;
    assign bus.busy[i]             = st != RX_IDLE && st != TX_IDLE;
    assign bus.rx_valid[i]         = rxv;
    assign bus.rx_data[i*32 +: 32] = rxd;
    assign bus.DAT_SEND[i*32 +: 32] = dsend;
    assign bus.timeout_err[i]      = err;
  end
endmodule

// File: tb/tb_transfer_dir_ctrl.sv
// tb_transfer_dir_ctrl: directed vectors checked against a side/phase model of each channel
module tb_transfer_dir_ctrl;
  localparam int N = 2, TURN = 4, TMO = 8;
  logic clk = 1'b0, rst = 1'b1;
  int vectors = 0, miscompares = 0;
  transfer_dir_ctrl_if #(.N(N)) bus();
  transfer_dir_ctrl #(.All_Channel(N), .TURN_CYC(TURN), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: side = direction being served, turn = turnaround cycles left,
  // hs = handshake phase (0 none, 1 request/ack held, 2 send release), wcnt = wait cycles
  bit side[N], mrxv[N], merr[N], rel, keep;
  int turn[N], hs[N], wcnt[N];
  logic [31:0] mrxd[N], mdat[N];
  always @(posedge clk)
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        side[c] = 0; turn[c] = 0; hs[c] = 0; wcnt[c] = 0;
        mrxv[c] = 0; merr[c] = 0; mrxd[c] = '0; mdat[c] = '0;
      end else begin
        rel = mrxv[c] && bus.rx_ready[c];
        merr[c] = merr[c] && !bus.clear_err[c];
        if (turn[c] > 0) turn[c]--;
        else if (hs[c] == 0) begin
          if (!side[c]) begin
            if (bus.dir_req[c]) begin side[c] = 1; turn[c] = TURN; end
            else if (bus.REQ_RECV[c] && !mrxv[c]) begin
              mrxd[c] = bus.DAT_RECV[c*32 +: 32]; mrxv[c] = 1; hs[c] = 1; wcnt[c] = 0;
            end
          end else begin
            if (!bus.dir_req[c]) begin side[c] = 0; turn[c] = TURN; end
            else if (bus.tx_valid[c]) begin
              mdat[c] = bus.tx_data[c*32 +: 32]; hs[c] = 1; wcnt[c] = 0;
            end
          end
        end else begin
          keep = side[c] ? (hs[c] == 1 ? !bus.ACK_SEND[c] : bus.ACK_SEND[c]) : bus.REQ_RECV[c];
          if (!keep) begin hs[c] = (side[c] && hs[c] == 1) ? 2 : 0; wcnt[c] = 0; end
          else if (++wcnt[c] == TMO) begin hs[c] = 0; merr[c] = 1; end
        end
        if (rel) mrxv[c] = 0;
      end
    end

  logic [N-1:0] e_oen, e_rdy, e_req, e_ack, e_busy, e_rxv, e_err;
  logic [N*32-1:0] e_rxd, e_dat;
  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      e_oen[c]  = !(side[c] && turn[c] == 0);
      e_rdy[c]  = side[c] && turn[c] == 0 && hs[c] == 0;
      e_req[c]  = side[c] && hs[c] == 1;
      e_ack[c]  = !side[c] && hs[c] == 1;
      e_busy[c] = turn[c] > 0 || hs[c] != 0;
      e_rxv[c]  = mrxv[c];
      e_err[c]  = merr[c];
      e_rxd[c*32 +: 32] = mrxd[c];
      e_dat[c*32 +: 32] = mdat[c];
    end
    chk("oen", 64'(bus.oen), 64'(e_oen));
    chk("tx_ready", 64'(bus.tx_ready), 64'(e_rdy));
    chk("REQ_SEND", 64'(bus.REQ_SEND), 64'(e_req));
    chk("ACK_RECV", 64'(bus.ACK_RECV), 64'(e_ack));
    chk("busy", 64'(bus.busy), 64'(e_busy));
    chk("rx_valid", 64'(bus.rx_valid), 64'(e_rxv));
    chk("timeout_err", 64'(bus.timeout_err), 64'(e_err));
    chk("rx_data", 64'(bus.rx_data), 64'(e_rxd));
    chk("DAT_SEND", 64'(bus.DAT_SEND), 64'(e_dat));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    {bus.dir_req, bus.tx_valid, bus.rx_ready, bus.ACK_SEND, bus.REQ_RECV, bus.clear_err} = '0;
    {bus.tx_data, bus.DAT_RECV} = '0;
    step(2);
    chk("rst_oen", 64'(bus.oen), 64'h3);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_dat", 64'(bus.DAT_SEND), 64'h0);
    rst = 1'b0;
    step(1);
    // receive on ch0
    bus.rx_ready[0] = 1'b1; bus.REQ_RECV[0] = 1'b1; bus.DAT_RECV[31:0] = 32'hA5A5_0001;
    step(1);
    chk("rx_capture", 64'(bus.rx_data[31:0]), 64'hA5A5_0001);
    chk("rx_valid_set", 64'(bus.rx_valid[0]), 64'h1);
    chk("ack_up", 64'(bus.ACK_RECV[0]), 64'h1);
    step(1);
    chk("rx_valid_pulse", 64'(bus.rx_valid[0]), 64'h0);
    chk("ack_hold", 64'(bus.ACK_RECV[0]), 64'h1);
    bus.REQ_RECV[0] = 1'b0;
    step(1);
    chk("ack_drop", 64'(bus.ACK_RECV[0]), 64'h0);
    // turnaround and send on ch0
    bus.dir_req[0] = 1'b1;
    for (int k = 0; k < TURN; k++) begin
      step(1);
      chk("turn_tx_oen", 64'(bus.oen[0]), 64'h1);
    end
    step(1);
    chk("tx_oen", 64'(bus.oen[0]), 64'h0);
    chk("tx_ready", 64'(bus.tx_ready[0]), 64'h1);
    bus.tx_valid[0] = 1'b1; bus.tx_data[31:0] = 32'h1234_5678;
    step(1);
    bus.tx_valid[0] = 1'b0; bus.tx_data[31:0] = '0;
    chk("req_send_up", 64'(bus.REQ_SEND[0]), 64'h1);
    step(2);
    bus.ACK_SEND[0] = 1'b1;
    step(2);
    chk("req_rel", 64'(bus.REQ_SEND[0]), 64'h0);
    chk("dat_held", 64'(bus.DAT_SEND[31:0]), 64'h1234_5678);
    bus.ACK_SEND[0] = 1'b0;
    step(1);
    chk("tx_idle_again", 64'(bus.tx_ready[0]), 64'h1);
    // send timeout, then set-beats-clear
    bus.tx_valid[0] = 1'b1; bus.tx_data[31:0] = 32'hDEAD_BEEF;
    step(1);
    bus.tx_valid[0] = 1'b0;
    step(TMO - 1);
    chk("req_before_tmo", 64'(bus.REQ_SEND[0]), 64'h1);
    step(1);
    chk("req_after_tmo", 64'(bus.REQ_SEND[0]), 64'h0);
    chk("err_set", 64'(bus.timeout_err[0]), 64'h1);
    bus.clear_err[0] = 1'b1;
    step(1);
    bus.clear_err[0] = 1'b0;
    chk("err_clear", 64'(bus.timeout_err[0]), 64'h0);
    bus.tx_valid[0] = 1'b1;
    step(1);
    bus.tx_valid[0] = 1'b0;
    step(TMO - 1);
    bus.clear_err[0] = 1'b1;
    step(1);
    chk("set_wins", 64'(bus.timeout_err[0]), 64'h1);
    step(1);
    bus.clear_err[0] = 1'b0;
    chk("cleared", 64'(bus.timeout_err[0]), 64'h0);
    // direction drop during handshake: completes, then turns to receive
    bus.tx_valid[0] = 1'b1; bus.tx_data[31:0] = 32'hCAFE_0001;
    step(1);
    bus.tx_valid[0] = 1'b0; bus.dir_req[0] = 1'b0;
    step(2);
    chk("no_abort", 64'(bus.REQ_SEND[0]), 64'h1);
    bus.ACK_SEND[0] = 1'b1;
    step(1);
    bus.ACK_SEND[0] = 1'b0;
    step(1);
    chk("back_tx_idle", 64'(bus.oen[0]), 64'h0);
    step(1);
    chk("turn_rx_oen", 64'(bus.oen[0]), 64'h1);
    step(TURN - 1);
    chk("turn_rx_busy", 64'(bus.busy[0]), 64'h1);
    step(1);
    chk("rx_idle", 64'(bus.busy[0]), 64'h0);
    // back-pressure on ch1
    bus.REQ_RECV[1] = 1'b1; bus.DAT_RECV[63:32] = 32'h1111_0001;
    step(1);
    chk("bp_ack1", 64'(bus.ACK_RECV[1]), 64'h1);
    bus.REQ_RECV[1] = 1'b0;
    step(1);
    bus.REQ_RECV[1] = 1'b1; bus.DAT_RECV[63:32] = 32'h2222_0002;
    step(3);
    chk("bp_no_ack", 64'(bus.ACK_RECV[1]), 64'h0);
    chk("bp_hold", 64'(bus.rx_data[63:32]), 64'h1111_0001);
    bus.rx_ready[1] = 1'b1;
    step(1);
    bus.rx_ready[1] = 1'b0;
    step(1);
    chk("bp_ack2", 64'(bus.ACK_RECV[1]), 64'h1);
    chk("bp_data2", 64'(bus.rx_data[63:32]), 64'h2222_0002);
    bus.REQ_RECV[1] = 1'b0; bus.rx_ready[1] = 1'b1;
    step(2);
    // receive timeout on ch0
    bus.REQ_RECV[0] = 1'b1; bus.DAT_RECV[31:0] = 32'h0BAD_0BAD;
    step(TMO + 1);
    bus.REQ_RECV[0] = 1'b0;
    chk("rx_tmo_ack", 64'(bus.ACK_RECV[0]), 64'h0);
    chk("rx_tmo_err", 64'(bus.timeout_err[0]), 64'h1);
    bus.clear_err[0] = 1'b1;
    step(1);
    bus.clear_err[0] = 1'b0;
    // reset mid-handshake on both channels
    bus.dir_req[1] = 1'b1;
    step(TURN + 1);
    bus.tx_valid[1] = 1'b1; bus.tx_data[63:32] = 32'h7777_0007;
    bus.REQ_RECV[0] = 1'b1; bus.DAT_RECV[31:0] = 32'h0000_00C0;
    step(1);
    bus.tx_valid[1] = 1'b0;
    chk("par_req1", 64'(bus.REQ_SEND[1]), 64'h1);
    chk("par_ack0", 64'(bus.ACK_RECV[0]), 64'h1);
    rst = 1'b1;
    step(1);
    chk("rst_oen_all", 64'(bus.oen), 64'h3);
    chk("rst_req", 64'(bus.REQ_SEND), 64'h0);
    chk("rst_ack", 64'(bus.ACK_RECV), 64'h0);
    chk("rst_rxv", 64'(bus.rx_valid), 64'h0);
    rst = 1'b0; bus.dir_req = '0; bus.REQ_RECV = '0;
    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
